// File: rtl/bkm_control_step_scoreboard.sv
// Result scoreboard for the bkm_control_step checker: aligns flags with deltas, keeps saturating
// event counts and per-lane worst |delta|, enforces an error budget and emits an end-of-test verdict.
module bkm_control_step_scoreboard #(
    parameter int W       = 64,
    parameter int CW      = 32,
    parameter int MAX_ERR = 1
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          srst,
    input  logic          enable,
    input  logic          eot,
    input  logic          err_u,
    input  logic          err_v,
    input  logic          war_u,
    input  logic          war_v,
    input  logic [W-1:0]  delta_u,
    input  logic [W-1:0]  delta_v,
    output logic [CW-1:0] chk_cnt,
    output logic [CW-1:0] err_cnt,
    output logic [CW-1:0] war_cnt,
    output logic [CW-1:0] pass_cnt,
    output logic [W-1:0]  max_du,
    output logic [W-1:0]  max_dv,
    output logic          stop_req,
    output logic          sum_valid,
    output logic          sum_pass,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         st;
    logic           en_d;
    logic [W-1:0]   du_d;
    logic [W-1:0]   dv_d;

    logic           e_u, e_v, wr_u, wr_v, w_u, w_v;
    logic           scoring, clean, hit;
    logic [CW-1:0]  err_next;

    assign state = st;

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] cnt, input logic [1:0] inc);
        logic [CW:0] s;
        s = {1'b0, cnt} + (CW+1)'(inc);
        return s[CW] ? {CW{1'b1}} : s[CW-1:0];
    endfunction

    // Two's complement magnitude; the most negative value maps onto itself, which is the correct unsigned result.
    function automatic logic [W-1:0] mag(input logic [W-1:0] d);
        return d[W-1] ? (~d + 1'b1) : d;
    endfunction

    // NOTE: every signal written here gets a value on every path first, so no latch can be inferred.
    always_comb begin
        e_u      = (err_u !== 1'b0);
        e_v      = (err_v !== 1'b0);
        wr_u     = (war_u !== 1'b0);
        wr_v     = (war_v !== 1'b0);
        w_u      = wr_u && !e_u;
        w_v      = wr_v && !e_v;
        clean    = !e_u && !e_v && !wr_u && !wr_v;
        scoring  = en_d && (st == IDLE || st == RUN);
        err_next = scoring ? sat_add(err_cnt, {1'b0, e_u} + {1'b0, e_v}) : err_cnt;
        hit      = scoring && (MAX_ERR != 0) && (err_next >= CW'(MAX_ERR));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            en_d <= 1'b0;
            du_d <= '0;
            dv_d <= '0;
        end else if (srst) begin
            en_d <= 1'b0;
            du_d <= '0;
            dv_d <= '0;
        end else begin
            en_d <= enable;
            du_d <= delta_u;
            dv_d <= delta_v;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            st        <= IDLE;
            chk_cnt   <= '0;
            err_cnt   <= '0;
            war_cnt   <= '0;
            pass_cnt  <= '0;
            max_du    <= '0;
            max_dv    <= '0;
            stop_req  <= 1'b0;
            sum_valid <= 1'b0;
            sum_pass  <= 1'b0;
        end else if (srst) begin
            st        <= IDLE;
            chk_cnt   <= '0;
            err_cnt   <= '0;
            war_cnt   <= '0;
            pass_cnt  <= '0;
            max_du    <= '0;
            max_dv    <= '0;
            stop_req  <= 1'b0;
            sum_valid <= 1'b0;
            sum_pass  <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            if (scoring) begin
                st       <= RUN;
                chk_cnt  <= sat_add(chk_cnt, 2'd1);
                err_cnt  <= err_next;
                war_cnt  <= sat_add(war_cnt, {1'b0, w_u} + {1'b0, w_v});
                pass_cnt <= sat_add(pass_cnt, {1'b0, clean});
                if (mag(du_d) > max_du) max_du <= mag(du_d);
                if (mag(dv_d) > max_dv) max_dv <= mag(dv_d);
            end
            if (hit) begin
                stop_req <= 1'b1;
                st       <= HALT;
            end
            // End of test wins over a same-cycle budget hit; the verdict sees this cycle's errors.
            if (eot && st != DONE) begin
                st        <= DONE;
                sum_valid <= 1'b1;
                sum_pass  <= (err_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_bkm_control_step_scoreboard.sv
// Bench for bkm_control_step_scoreboard: two instances (budget 3 and budget disabled) share stimulus
// and are compared every cycle against a transaction-level reference model.
module tb_bkm_control_step_scoreboard;

    localparam int W   = 8;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic         clk = 1'b0;
    logic         arst, srst, enable, eot;
    logic         err_u, err_v, war_u, war_v;
    logic [W-1:0] delta_u, delta_v;

    logic [CW-1:0] chk_o[2], err_o[2], war_o[2], pass_o[2];
    logic [W-1:0]  mdu_o[2], mdv_o[2];
    logic          stop_o[2], sv_o[2], sp_o[2];
    logic [1:0]    st_o[2];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, one slot per instance.
    int m_budget[2] = '{3, 0};
    int m_chk[2], m_err[2], m_war[2], m_pass[2], m_mdu[2], m_mdv[2];
    int m_stop[2], m_sv[2], m_sp[2];
    int m_phase[2];  // 0 idle, 1 run, 2 halted, 3 done
    bit pend;
    int pend_du, pend_dv;

    always #5 clk = ~clk;

    bkm_control_step_scoreboard #(.W(W), .CW(CW), .MAX_ERR(3)) dut_a (
        .clk(clk), .arst(arst), .srst(srst), .enable(enable), .eot(eot),
        .err_u(err_u), .err_v(err_v), .war_u(war_u), .war_v(war_v),
        .delta_u(delta_u), .delta_v(delta_v),
        .chk_cnt(chk_o[0]), .err_cnt(err_o[0]), .war_cnt(war_o[0]), .pass_cnt(pass_o[0]),
        .max_du(mdu_o[0]), .max_dv(mdv_o[0]), .stop_req(stop_o[0]),
        .sum_valid(sv_o[0]), .sum_pass(sp_o[0]), .state(st_o[0])
    );

    bkm_control_step_scoreboard #(.W(W), .CW(CW), .MAX_ERR(0)) dut_b (
        .clk(clk), .arst(arst), .srst(srst), .enable(enable), .eot(eot),
        .err_u(err_u), .err_v(err_v), .war_u(war_u), .war_v(war_v),
        .delta_u(delta_u), .delta_v(delta_v),
        .chk_cnt(chk_o[1]), .err_cnt(err_o[1]), .war_cnt(war_o[1]), .pass_cnt(pass_o[1]),
        .max_du(mdu_o[1]), .max_dv(mdv_o[1]), .stop_req(stop_o[1]),
        .sum_valid(sv_o[1]), .sum_pass(sp_o[1]), .state(st_o[1])
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    function automatic int absval(input int d);
        return (d >= 128) ? 256 - d : d;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_chk[k] = 0; m_err[k] = 0; m_war[k] = 0; m_pass[k] = 0;
            m_mdu[k] = 0; m_mdv[k] = 0; m_stop[k] = 0; m_sv[k] = 0; m_sp[k] = 0;
            m_phase[k] = 0;
        end
        pend = 1'b0; pend_du = 0; pend_dv = 0;
    endtask

    // Applies the rules for the clock edge about to happen, given the inputs currently driven.
    task automatic model_step();
        int eu, ev, wu, wv;
        if (srst) begin
            model_reset();
            return;
        end
        eu = int'(err_u);
        ev = int'(err_v);
        wu = (war_u && !err_u) ? 1 : 0;
        wv = (war_v && !err_v) ? 1 : 0;
        for (int k = 0; k < 2; k++) begin
            m_sv[k] = 0;
            if (pend && m_phase[k] < 2) begin
                m_chk[k]  = sat(m_chk[k] + 1);
                m_err[k]  = sat(m_err[k] + eu + ev);
                m_war[k]  = sat(m_war[k] + wu + wv);
                if (!err_u && !err_v && !war_u && !war_v) m_pass[k] = sat(m_pass[k] + 1);
                if (absval(pend_du) > m_mdu[k]) m_mdu[k] = absval(pend_du);
                if (absval(pend_dv) > m_mdv[k]) m_mdv[k] = absval(pend_dv);
                m_phase[k] = 1;
                if (m_budget[k] != 0 && m_err[k] >= m_budget[k]) begin
                    m_stop[k]  = 1;
                    m_phase[k] = 2;
                end
            end
            if (eot && m_phase[k] != 3) begin
                m_phase[k] = 3;
                m_sv[k]    = 1;
                m_sp[k]    = (m_err[k] == 0) ? 1 : 0;
            end
        end
        pend    = enable;
        pend_du = int'(delta_u);
        pend_dv = int'(delta_v);
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("chk_cnt[%0d]", k),   int'(chk_o[k]),  m_chk[k]);
            check($sformatf("err_cnt[%0d]", k),   int'(err_o[k]),  m_err[k]);
            check($sformatf("war_cnt[%0d]", k),   int'(war_o[k]),  m_war[k]);
            check($sformatf("pass_cnt[%0d]", k),  int'(pass_o[k]), m_pass[k]);
            check($sformatf("max_du[%0d]", k),    int'(mdu_o[k]),  m_mdu[k]);
            check($sformatf("max_dv[%0d]", k),    int'(mdv_o[k]),  m_mdv[k]);
            check($sformatf("stop_req[%0d]", k),  int'(stop_o[k]), m_stop[k]);
            check($sformatf("sum_valid[%0d]", k), int'(sv_o[k]),   m_sv[k]);
            check($sformatf("sum_pass[%0d]", k),  int'(sp_o[k]),   m_sp[k]);
            check($sformatf("state[%0d]", k),     int'(st_o[k]),   m_phase[k]);
        end
    endtask

    // One clock cycle: flags belong to the check enabled in the previous cycle.
    task automatic cyc(input logic en, input logic [W-1:0] du, input logic [W-1:0] dv,
                       input logic eu, input logic ev, input logic wu, input logic wv,
                       input logic e, input logic sr);
        enable = en; delta_u = du; delta_v = dv;
        err_u = eu; err_v = ev; war_u = wu; war_v = wv;
        eot = e; srst = sr;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic arst_pulse();
        #3 arst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1 arst = 1'b0;
    endtask

    function automatic logic [W-1:0] pick_delta();
        case ($urandom_range(0, 4))
            0: return 8'h80;
            1: return 8'hFF;
            2: return 8'h7F;
            3: return 8'h00;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        arst = 1'b1; srst = 1'b0; enable = 1'b0; eot = 1'b0;
        err_u = 1'b0; err_v = 1'b0; war_u = 1'b0; war_v = 1'b0;
        delta_u = '0; delta_v = '0;
        model_reset();
        #2 check_all();
        #20 arst = 1'b0;

        // Clean run: ten back-to-back checks, then end of test.
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
        cyc(1'b0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
        check("t2_chk", int'(chk_o[0]), 10);
        cyc(1'b0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 0);
        check("t2_sum_pass", int'(sp_o[0]), 1);
        cyc(1'b0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);

        // Enable during srst must not be captured.
        cyc(1'b1, 8'h05, 8'h05, 0, 0, 0, 0, 0, 1);
        cyc(1'b0, 8'h00, 8'h00, 1, 1, 0, 0, 0, 0);
        cyc(1'b0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);

        // Single warning plus magnitude corner cases on lane v.
        cyc(1'b1, 8'h01, 8'h80, 0, 0, 0, 0, 0, 0);
        cyc(1'b1, 8'h00, 8'hFF, 0, 0, 1, 0, 0, 0);
        cyc(1'b0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
        check("t3_war", int'(war_o[0]), 1);
        check("t5_max_dv", int'(mdv_o[0]), 128);

        // Error budget: two double-error checks halt instance a; later checks are ignored there.
        cyc(1'b1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);
        cyc(1'b1, 8'h00, 8'h00, 1, 1, 0, 0, 0, 0);
        cyc(1'b1, 8'h00, 8'h00, 1, 1, 1, 1, 0, 0);
        cyc(1'b0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0);
        check("t4_stop", int'(stop_o[0]), 1);
        cyc(1'b0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 0);

        // Randomised traffic with occasional end-of-test and synchronous reset.
        cyc(1'b0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(0, 1) == 1, pick_delta(), pick_delta(),
                $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 79) == 0, $urandom_range(0, 49) == 0);
            if (i == 400) arst_pulse();
        end

        // Saturation: sixteen double-error checks overflow both 4-bit counters.
        arst_pulse();
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'h00, 8'h00, 1, 1, 0, 0, 0, 0);
        cyc(1'b0, 8'h00, 8'h00, 1, 1, 0, 0, 0, 0);
        check("t6_err_sat", int'(err_o[1]), 15);
        cyc(1'b0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 0);
        check("t6_sum_pass", int'(sp_o[1]), 0);
        cyc(1'b0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
